// File: rtl/rx_packer_fifo.sv
// Receive-side byte packer feeding a word FIFO: assembles little-endian words from
// the QSPI shift engine and buffers them for the register interface.
module rx_packer_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clear_i,
    input  logic                       byte_valid_i,
    input  logic [7:0]                 byte_data_i,
    input  logic                       last_i,
    input  logic                       flush_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic                       partial_o
);

    localparam int LANES = WIDTH / 8;
    localparam int LW    = $clog2(LANES);
    localparam int AW    = $clog2(DEPTH);

    logic [LW-1:0]    lane_q;
    logic [WIDTH-1:0] acc_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             ovf_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] word_next;
    logic             word_done;
    logic             push;
    logic             pop;

    function automatic logic [AW:0] next_level(input logic [AW:0] lvl,
                                               input logic inc, input logic dec);
        logic [AW:0] res;
        res = lvl;
        if (inc && !dec && lvl != (AW+1)'(DEPTH)) res = lvl + (AW+1)'(1);
        else if (dec && !inc && lvl != '0)        res = lvl - (AW+1)'(1);
        return res;
    endfunction

    always_comb begin
        word_next = acc_q;
        for (int i = 0; i < LANES; i++) begin
            if (byte_valid_i && lane_q == LW'(i)) word_next[8*i +: 8] = byte_data_i;
        end
        word_done = (byte_valid_i && (lane_q == LW'(LANES-1) || last_i)) ||
                    (flush_i && (lane_q != '0 || byte_valid_i));
        // Overflow is judged on the pre-edge full flag, so a same-edge pop cannot rescue a word.
        push = !clear_i && word_done && !full_o;
        pop  = !clear_i && rd_en_i && !empty_o;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lane_q   <= '0;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (clear_i) begin
            lane_q   <= '0;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (word_done) begin
                lane_q <= '0;
                acc_q  <= '0;
                if (full_o) ovf_q <= 1'b1;
            end else if (byte_valid_i) begin
                lane_q <= lane_q + LW'(1);
                acc_q  <= word_next;
            end
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= next_level(level_q, push, pop);
        end
    end

    // Storage is intentionally not reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= word_next;
    end

    assign rd_data_o  = mem[rd_ptr_q];
    assign empty_o    = (level_q == '0);
    assign full_o     = (level_q == (AW+1)'(DEPTH));
    assign level_o    = level_q;
    assign overflow_o = ovf_q;
    assign partial_o  = (lane_q != '0);

endmodule

// File: tb/tb_rx_packer_fifo.sv
// Scoreboard bench for rx_packer_fifo: a behavioural packer model queues expected
// words as bytes are driven; words are compared as they are popped.
module tb_rx_packer_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int LANES = WIDTH / 8;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             clear_i = 1'b0;
    logic             byte_valid_i = 1'b0;
    logic [7:0]       byte_data_i = '0;
    logic             last_i = 1'b0;
    logic             flush_i = 1'b0;
    logic             rd_en_i = 1'b0;
    logic [WIDTH-1:0] rd_data_o;
    logic             empty_o;
    logic             full_o;
    logic [$clog2(DEPTH):0] level_o;
    logic             overflow_o;
    logic             partial_o;

    rx_packer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .clear_i(clear_i),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .last_i(last_i),
        .flush_i(flush_i), .rd_en_i(rd_en_i), .rd_data_o(rd_data_o),
        .empty_o(empty_o), .full_o(full_o), .level_o(level_o),
        .overflow_o(overflow_o), .partial_o(partial_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] sb_q[$];
    int               m_lane = 0;
    logic [WIDTH-1:0] m_acc = '0;
    bit               m_ovf = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_level"},   64'(level_o),    64'(sb_q.size()));
        check({tag, "_empty"},   64'(empty_o),    64'(sb_q.size() == 0));
        check({tag, "_full"},    64'(full_o),     64'(sb_q.size() == DEPTH));
        check({tag, "_ovf"},     64'(overflow_o), 64'(m_ovf));
        check({tag, "_partial"}, 64'(partial_o),  64'(m_lane != 0));
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_lane = 0;
        m_acc  = '0;
        m_ovf  = 1'b0;
    endtask

    // Drive one cycle of inputs, update the model for that edge, then check flags.
    task automatic step(input bit bv, input logic [7:0] bd, input bit lst,
                        input bit fl, input bit rd, input bit clr);
        logic [WIDTH-1:0] word;
        bit done, was_full;
        byte_valid_i = bv; byte_data_i = bd; last_i = lst;
        flush_i = fl; rd_en_i = rd; clear_i = clr;
        if (clr) begin
            model_reset();
        end else begin
            word = m_acc;
            if (bv) word[8*m_lane +: 8] = bd;
            done = (bv && (m_lane == LANES-1 || lst)) || (fl && (m_lane != 0 || bv));
            was_full = (sb_q.size() == DEPTH);
            if (rd && sb_q.size() > 0) begin
                check("pop_data", 64'(rd_data_o), 64'(sb_q[0]));
                void'(sb_q.pop_front());
            end
            if (done) begin
                if (was_full) m_ovf = 1'b1;
                else sb_q.push_back(word);
                m_acc = '0;
                m_lane = 0;
            end else if (bv) begin
                m_acc = word;
                m_lane++;
            end
        end
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0; last_i = 1'b0; flush_i = 1'b0; rd_en_i = 1'b0; clear_i = 1'b0;
        check_flags("step");
    endtask

    task automatic send_byte(input logic [7:0] b, input bit lst);
        step(1'b1, b, lst, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        while (sb_q.size() > 0) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        check_flags("reset");
        resetn = 1'b1;
        @(posedge clk); #1;

        // Four bytes form one little-endian word.
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
        check("w4_level", 64'(level_o), 64'd1);
        check("w4_data", 64'(rd_data_o), 64'h44332211);
        check("w4_partial", 64'(partial_o), 64'd0);
        drain();

        // Short transfer terminated by last_i.
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b1);
        check("last_data", 64'(rd_data_o), 64'h00CCBBAA);
        check("last_partial", 64'(partial_o), 64'd0);
        drain();

        // Overfill by one word.
        for (int n = 0; n <= DEPTH; n++) begin
            send_byte(8'(n), 1'b0);
            for (int k = 1; k < LANES; k++) send_byte(8'h00, 1'b0);
        end
        check("ovf_full", 64'(full_o), 64'd1);
        check("ovf_level", 64'(level_o), 64'(DEPTH));
        check("ovf_flag", 64'(overflow_o), 64'd1);
        drain();
        check("ovf_empty", 64'(empty_o), 64'd1);
        check("ovf_sticky", 64'(overflow_o), 64'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);   // pop while empty is ignored
        check("empty_pop_level", 64'(level_o), 64'd0);

        // Simultaneous push and pop at level 5.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 5; n++) begin
            send_byte(8'h10 + 8'(n), 1'b0);
            for (int k = 1; k < LANES; k++) send_byte(8'h00, 1'b0);
        end
        send_byte(8'hE1, 1'b0); send_byte(8'hE2, 1'b0); send_byte(8'hE3, 1'b0);
        step(1'b1, 8'hE4, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pushpop_level", 64'(level_o), 64'd5);
        for (int n = 0; n < 4; n++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pushpop_lastword", 64'(rd_data_o), 64'hE4E3E2E1);
        drain();

        // Clear in the middle of a word discards it.
        send_byte(8'h77, 1'b0); send_byte(8'h88, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int n = 1; n <= 4; n++) send_byte(8'(n), 1'b0);
        check("clear_data", 64'(rd_data_o), 64'h04030201);
        check("clear_ovf", 64'(overflow_o), 64'd0);
        drain();

        // Flush behaviour.
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("flush_noop_level", 64'(level_o), 64'd0);
        send_byte(8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("flush_data", 64'(rd_data_o), 64'h0000005A);
        step(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);   // flush together with a byte
        drain();

        // Asynchronous reset mid-word.
        send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check("areset_partial", 64'(partial_o), 64'd0);
        check("areset_level", 64'(level_o), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int n = 0; n < 4; n++) send_byte(8'hA0 + 8'(n), 1'b0);
        check("areset_data", 64'(rd_data_o), 64'hA3A2A1A0);
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
